mem_access_unit: RTL and testbench

- Memory-side stage directly downstream of the multi-cycle control FSM.
- Converts the FSM's per-state memory commands (fetch, load, store) into a single valid/ready transaction on the external memory port.
- Handles byte/half/word lane alignment, write strobes and load sign/zero extension, and latches the instruction register, old PC and load-data register.
- Reports busy/done so the FSM can stall while memory is slow.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit_lane_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access stage: funct3 sizes, the NOP, FSM states and request kinds.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  typedef enum logic [1:0] {FETCH, READ, WRITE} kind_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// External memory port: single outstanding valid/ready transaction, held stable until mem_ready.
interface mem_access_unit_if;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, load extension and misalign detection.
module lsu_lane_align
  import mem_access_unit_pkg::*;
(
  input  kind_e       kind_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic        is_byte;
  logic        is_half;
  logic        sext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    is_byte    = 1'b0;
    is_half    = 1'b0;
    sext       = ~funct3_i[2];
    byte_v     = rdata_i[{off_i, 3'b000} +: 8];
    half_v     = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wstrb_o    = 4'b1111;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = (off_i != 2'b00);

    // LBU/LHU encodings are only sized accesses for loads; for stores they fall back to a word
    if (kind_i != FETCH) begin
      is_byte = (funct3_i == F3_SB) || (kind_i == READ && funct3_i == F3_LBU);
      is_half = (funct3_i == F3_SH) || (kind_i == READ && funct3_i == F3_LHU);
    end

    if (is_byte) begin
      wstrb_o    = 4'b0001 << off_i;
      wdata_o    = {4{wdata_i[7:0]}};
      rdata_o    = {{24{sext & byte_v[7]}}, byte_v};
      misalign_o = 1'b0;
    end else if (is_half) begin
      wstrb_o    = 4'b0011 << off_i;
      wdata_o    = {2{wdata_i[15:0]}};
      rdata_o    = {{16{sext & half_v[15]}}, half_v};
      misalign_o = off_i[0];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Turns fetch/load/store commands from the control FSM into one memory bus transaction each.
// Request to done is two cycles with a ready memory; busy stalls the FSM while memory is slow.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_INSTR    = NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_fetch,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] addr_pc,
  input  logic [31:0] addr_alu,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] instr,
  output logic [31:0] old_pc,
  output logic [31:0] mem_data,
  mem_access_unit_if.master mem
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] mem_data_q, mem_data_d;

  logic        req_vld;
  kind_e       req_kind;
  logic [31:0] req_addr;
  logic        idle;
  kind_e       al_kind;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;

  always_comb begin
    req_vld = req_fetch | req_write | req_read;
    if (req_fetch) begin
      req_kind = FETCH;
      req_addr = addr_pc;
    end else if (req_write) begin
      req_kind = WRITE;
      req_addr = addr_alu;
    end else begin
      req_kind = READ;
      req_addr = addr_alu;
    end
    // The aligner checks the incoming request while idle and steers the registered one otherwise
    idle    = (state_q == IDLE);
    al_kind = idle ? req_kind : kind_q;
    al_f3   = idle ? funct3 : f3_q;
    al_off  = idle ? req_addr[1:0] : addr_q[1:0];
  end

  lsu_lane_align u_align (
    .kind_i     (al_kind),
    .funct3_i   (al_f3),
    .off_i      (al_off),
    .wdata_i    (wdata),
    .rdata_i    (mem.mem_rdata),
    .wstrb_o    (al_wstrb),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    instr_d    = instr_q;
    old_pc_d   = old_pc_q;
    mem_data_d = mem_data_q;

    case (state_q)
      IDLE: begin
        if (req_vld) begin
          kind_d  = req_kind;
          addr_d  = req_addr;
          f3_d    = funct3;
          strb_d  = (req_kind == WRITE) ? al_wstrb : 4'b0000;
          wdata_d = al_wdata;
          if (al_misalign) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (mem.mem_ready) begin
          state_d = RESP;
          cnt_d   = '0;
          if (kind_q == FETCH) begin
            instr_d  = mem.mem_rdata;
            old_pc_d = addr_q;
          end else if (kind_q == READ) begin
            mem_data_d = al_rdata;
          end
        end else if (TIMEOUT_CYCLES != 0 && cnt_q + 32'd1 == TIMEOUT_CYCLES) begin
          state_d = RESP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      kind_q     <= FETCH;
      addr_q     <= '0;
      f3_q       <= '0;
      strb_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      instr_q    <= RESET_INSTR;
      old_pc_q   <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      addr_q     <= addr_d;
      f3_q       <= f3_d;
      strb_q     <= strb_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      instr_q    <= instr_d;
      old_pc_q   <= old_pc_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == RESP);
  assign err           = err_q;
  assign instr         = instr_q;
  assign old_pc        = old_pc_q;
  assign mem_data      = mem_data_q;
  assign mem.mem_valid = (state_q == BUS);
  assign mem.mem_we    = (state_q == BUS) && (kind_q == WRITE);
  assign mem.mem_addr  = {addr_q[31:2], 2'b00};
  assign mem.mem_wstrb = (state_q == BUS) ? strb_q : 4'b0000;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single transactions plus slow-memory,
// timeout and mid-transaction reset sequences.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_fetch, req_read, req_write;
  logic [31:0] addr_pc, addr_alu, wdata;
  logic [2:0]  funct3;
  logic        busy, done, err;
  logic [31:0] instr, old_pc, mem_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit_if mif ();

  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .RESET_INSTR    (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_fetch (req_fetch),
    .req_read  (req_read),
    .req_write (req_write),
    .addr_pc   (addr_pc),
    .addr_alu  (addr_alu),
    .funct3    (funct3),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .instr     (instr),
    .old_pc    (old_pc),
    .mem_data  (mem_data),
    .mem       (mif)
  );

  typedef struct {
    logic        f, r, w;
    logic [31:0] pc, alu;
    logic [2:0]  f3;
    logic [31:0] wd, rd;
    logic [31:0] e_addr;
    logic        e_we;
    logic [3:0]  e_strb;
    logic [31:0] e_wd, e_instr, e_pc, e_md;
    logic        e_err;
  } vec_t;

  vec_t v [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req;
    req_fetch = 1'b0;
    req_read  = 1'b0;
    req_write = 1'b0;
  endtask

  initial begin
    // f r w | pc alu f3 wdata rdata | addr we strb wdata | instr old_pc mem_data err
    v[0]  = '{1,0,0, 32'h100, 32'h0,   F3_LW,  32'h0,        32'h00500093, 32'h100, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'h0,        0};
    v[1]  = '{0,0,1, 32'h0,   32'h203, F3_SB,  32'h000000AB, 32'h0,        32'h200, 1, 4'h8, 32'hABABABAB, 32'h00500093, 32'h100, 32'h0,        0};
    v[2]  = '{0,1,0, 32'h0,   32'h202, F3_LB,  32'h0,        32'h00800000, 32'h200, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'hFFFFFF80, 0};
    v[3]  = '{0,1,0, 32'h0,   32'h202, F3_LBU, 32'h0,        32'h00800000, 32'h200, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'h00000080, 0};
    v[4]  = '{0,1,0, 32'h0,   32'h202, F3_LH,  32'h0,        32'h80010000, 32'h200, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'hFFFF8001, 0};
    v[5]  = '{0,1,0, 32'h0,   32'h200, F3_LHU, 32'h0,        32'h80018765, 32'h200, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'h00008765, 0};
    v[6]  = '{0,1,0, 32'h0,   32'h204, F3_LW,  32'h0,        32'hDEADBEEF, 32'h204, 0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'hDEADBEEF, 0};
    v[7]  = '{0,1,0, 32'h0,   32'h206, F3_LW,  32'h0,        32'h12345678, 32'h0,   0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'hDEADBEEF, 1};
    v[8]  = '{0,0,1, 32'h0,   32'h202, F3_SH,  32'h1234ABCD, 32'h0,        32'h200, 1, 4'hC, 32'hABCDABCD, 32'h00500093, 32'h100, 32'hDEADBEEF, 0};
    v[9]  = '{0,0,1, 32'h0,   32'h208, F3_SW,  32'hCAFEF00D, 32'h0,        32'h208, 1, 4'hF, 32'hCAFEF00D, 32'h00500093, 32'h100, 32'hDEADBEEF, 0};
    v[10] = '{0,1,0, 32'h0,   32'h201, F3_LH,  32'h0,        32'h0,        32'h0,   0, 4'h0, 32'h0,        32'h00500093, 32'h100, 32'hDEADBEEF, 1};
    v[11] = '{1,0,1, 32'h104, 32'h300, F3_SW,  32'h00000055, 32'h00A00113, 32'h104, 0, 4'h0, 32'h0,        32'h00A00113, 32'h104, 32'hDEADBEEF, 0};
    v[12] = '{1,0,0, 32'h102, 32'h0,   F3_LW,  32'h0,        32'hFFFFFFFF, 32'h0,   0, 4'h0, 32'h0,        32'h00A00113, 32'h104, 32'hDEADBEEF, 1};
    v[13] = '{0,0,1, 32'h0,   32'h201, F3_SB,  32'h0000005A, 32'h0,        32'h200, 1, 4'h2, 32'h5A5A5A5A, 32'h00A00113, 32'h104, 32'hDEADBEEF, 0};
    v[14] = '{0,1,0, 32'h0,   32'h203, F3_LB,  32'h0,        32'h7F000000, 32'h200, 0, 4'h0, 32'h0,        32'h00A00113, 32'h104, 32'h0000007F, 0};
    v[15] = '{0,1,1, 32'h0,   32'h20C, F3_SW,  32'h01020304, 32'h0,        32'h20C, 1, 4'hF, 32'h01020304, 32'h00A00113, 32'h104, 32'h0000007F, 0};

    rst = 1'b1;
    clear_req();
    addr_pc = '0; addr_alu = '0; funct3 = '0; wdata = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    #22;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_valid", {31'd0, mif.mem_valid}, 32'd0);
    chk("rst_we",    {31'd0, mif.mem_we}, 32'd0);
    chk("rst_addr",  mif.mem_addr, 32'h0);
    chk("rst_wstrb", {28'd0, mif.mem_wstrb}, 32'd0);
    chk("rst_wdata", mif.mem_wdata, 32'h0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_oldpc", old_pc, 32'h0);
    chk("rst_mdata", mem_data, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      req_fetch = v[i].f; req_read = v[i].r; req_write = v[i].w;
      addr_pc = v[i].pc; addr_alu = v[i].alu; funct3 = v[i].f3; wdata = v[i].wd;
      mif.mem_ready = 1'b1;
      mif.mem_rdata = v[i].rd;
      tick();
      clear_req();
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      if (v[i].e_err) begin
        chk($sformatf("v%0d_valid", i), {31'd0, mif.mem_valid}, 32'd0);
        chk($sformatf("v%0d_done", i),  {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_err", i),   {31'd0, err}, 32'd1);
      end else begin
        chk($sformatf("v%0d_valid", i), {31'd0, mif.mem_valid}, 32'd1);
        chk($sformatf("v%0d_addr", i),  mif.mem_addr, v[i].e_addr);
        chk($sformatf("v%0d_we", i),    {31'd0, mif.mem_we}, {31'd0, v[i].e_we});
        chk($sformatf("v%0d_wstrb", i), {28'd0, mif.mem_wstrb}, {28'd0, v[i].e_strb});
        if (v[i].e_we) chk($sformatf("v%0d_wdata", i), mif.mem_wdata, v[i].e_wd);
        chk($sformatf("v%0d_done_early", i), {31'd0, done}, 32'd0);
        tick();
        chk($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_err", i),  {31'd0, err}, 32'd0);
      end
      chk($sformatf("v%0d_instr", i), instr, v[i].e_instr);
      chk($sformatf("v%0d_oldpc", i), old_pc, v[i].e_pc);
      chk($sformatf("v%0d_mdata", i), mem_data, v[i].e_md);
      tick();
      chk($sformatf("v%0d_idle", i), {31'd0, busy}, 32'd0);
    end

    // Slow memory: three BUS cycles without ready, a store request while busy must be ignored
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'h11111111;
    req_fetch = 1'b1; addr_pc = 32'h110;
    tick();
    clear_req();
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("slow_valid%0d", c), {31'd0, mif.mem_valid}, 32'd1);
      chk($sformatf("slow_addr%0d", c),  mif.mem_addr, 32'h110);
      chk($sformatf("slow_done%0d", c),  {31'd0, done}, 32'd0);
      req_write = (c == 2); addr_alu = 32'h400; funct3 = F3_SW;
      tick();
    end
    req_write = 1'b0;
    chk("slow_valid4", {31'd0, mif.mem_valid}, 32'd1);
    chk("slow_addr4",  mif.mem_addr, 32'h110);
    mif.mem_ready = 1'b1;
    tick();
    chk("slow_done",  {31'd0, done}, 32'd1);
    chk("slow_err",   {31'd0, err}, 32'd0);
    chk("slow_instr", instr, 32'h11111111);
    chk("slow_oldpc", old_pc, 32'h110);
    tick();
    tick();
    chk("slow_ignored_valid", {31'd0, mif.mem_valid}, 32'd0);
    chk("slow_ignored_busy",  {31'd0, busy}, 32'd0);

    // Timeout after four BUS cycles with ready stuck low
    mif.mem_ready = 1'b0;
    mif.mem_rdata = 32'hBAD0BAD0;
    req_read = 1'b1; addr_alu = 32'h210; funct3 = F3_LW;
    tick();
    clear_req();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_valid%0d", c), {31'd0, mif.mem_valid}, 32'd1);
      chk($sformatf("to_done%0d", c),  {31'd0, done}, 32'd0);
      tick();
    end
    chk("to_valid_drop", {31'd0, mif.mem_valid}, 32'd0);
    chk("to_done",  {31'd0, done}, 32'd1);
    chk("to_err",   {31'd0, err}, 32'd1);
    chk("to_mdata", mem_data, 32'h0000007F);
    tick();
    chk("to_done_end", {31'd0, done}, 32'd0);
    chk("to_busy_end", {31'd0, busy}, 32'd0);

    // Reset in the middle of a BUS cycle, then a clean fetch
    req_fetch = 1'b1; addr_pc = 32'h120;
    tick();
    clear_req();
    chk("mrst_valid_pre", {31'd0, mif.mem_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, mif.mem_valid}, 32'd0);
    chk("mrst_busy",  {31'd0, busy}, 32'd0);
    chk("mrst_instr", instr, 32'h00000013);
    chk("mrst_addr",  mif.mem_addr, 32'h0);
    chk("mrst_mdata", mem_data, 32'h0);
    tick();
    rst = 1'b0;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'h00000033;
    tick();
    req_fetch = 1'b1; addr_pc = 32'h130;
    tick();
    clear_req();
    chk("post_valid", {31'd0, mif.mem_valid}, 32'd1);
    chk("post_addr",  mif.mem_addr, 32'h130);
    tick();
    chk("post_done",  {31'd0, done}, 32'd1);
    chk("post_err",   {31'd0, err}, 32'd0);
    chk("post_instr", instr, 32'h00000033);
    chk("post_oldpc", old_pc, 32'h130);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
